sha256_block_sequencer: RTL

Controller that sequences the single-block SHA-256 core for the feedback-mode KDF.
- Accepts one 512-bit message block as a stream of 16 32-bit words and buffers it.
- Drives the core's start/load/read handshake: soc pulse, 16 back-to-back data words, wait for eoc, 8 rd cycles.
- Returns the 256-bit digest through a valid/ready port.
- Sits between the KDF round controller (upstream and downstream) and the SHA-256 core's bidirectional bus.

---
 rtl/kdf_pkg.sv | 20 ++
 rtl/sha_block_buf.sv | 23 ++
 rtl/sha256_block_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/kdf_pkg.sv
// Shared constants and state encoding for the KDF SHA-256 block sequencer.
package kdf_pkg;

  localparam int BLOCK_WORDS            = 16;
  localparam int DIGEST_WORDS           = 8;
  localparam int WORD_W                 = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_FEED,
    ST_WAIT,
    ST_READ,
    ST_DONE,
    ST_DRAIN
  } seq_state_e;

endpackage

// File: rtl/sha_block_buf.sv
// 16x32 message block buffer: one synchronous write port, one asynchronous read port.
module sha_block_buf
  import kdf_pkg::*;
(
  input  logic                           clk,
  input  logic                           i_we,
  input  logic [$clog2(BLOCK_WORDS)-1:0] i_waddr,
  input  logic [WORD_W-1:0]              i_wdata,
  input  logic [$clog2(BLOCK_WORDS)-1:0] i_raddr,
  output logic [WORD_W-1:0]              o_rdata
);

  logic [WORD_W-1:0] r_mem [BLOCK_WORDS];

  // NOTE: no reset on the storage array; every entry is rewritten before it is
  // fed, and a reset in the middle of a block must leave the contents alone.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sha256_block_sequencer.sv
// Buffers one 512-bit block, runs the SHA-256 core's soc/feed/eoc/rd handshake
// and hands the 256-bit digest downstream over valid/ready.
module sha256_block_sequencer
  import kdf_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] dig_data,
  output logic         busy,
  output logic         err,
  output logic         sha_soc,
  output logic [31:0]  sha_data_o,
  output logic         sha_data_oe,
  input  logic [31:0]  sha_data_i,
  output logic         sha_rd,
  input  logic         sha_eoc
);

  localparam int                TCNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]        WCNT_LAST  = 4'(BLOCK_WORDS - 1);
  localparam logic [2:0]        RCNT_LAST  = 3'(DIGEST_WORDS - 1);

  seq_state_e         r_state, w_state_nxt;
  logic [3:0]         r_wcnt, w_wcnt_nxt;
  logic [3:0]         r_fcnt, w_fcnt_nxt;
  logic [2:0]         r_rcnt, w_rcnt_nxt;
  logic [TCNT_W-1:0]  r_tcnt, w_tcnt_nxt;
  logic               w_err_nxt;
  logic               w_buf_we;
  logic               w_in_fire;
  logic [WORD_W-1:0]  w_buf_rdata;
  logic [7:0]         w_dig_lsb;

  logic               r_err, r_busy, r_sha_soc, r_sha_data_oe, r_sha_rd, r_dig_valid;
  logic [31:0]        r_sha_data_o;
  logic [255:0]       r_dig_data;

  // The read address is the FEED index of the coming cycle so the bus word
  // can be registered one edge ahead.
  sha_block_buf u_buf (
    .clk     (clk),
    .i_we    (w_buf_we),
    .i_waddr (r_wcnt),
    .i_wdata (in_data),
    .i_raddr (w_fcnt_nxt),
    .o_rdata (w_buf_rdata)
  );

  assign in_ready  = !rst && (r_state == ST_IDLE || r_state == ST_LOAD || r_state == ST_DRAIN);
  assign w_in_fire = in_valid && in_ready;
  // Digest word 0 (H0) lands in the top slice, word 7 in the bottom one.
  assign w_dig_lsb = {~r_rcnt, 5'b0};

  always_comb begin
    // NOTE: every signal gets its default first so no path through the case
    // can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_fcnt_nxt  = r_fcnt;
    w_rcnt_nxt  = r_rcnt;
    w_tcnt_nxt  = r_tcnt;
    w_err_nxt   = 1'b0;
    w_buf_we    = 1'b0;
    case (r_state)
      ST_IDLE, ST_LOAD: begin
        if (w_in_fire) begin
          w_buf_we = 1'b1;
          if (r_wcnt == WCNT_LAST) begin
            w_state_nxt = in_last ? ST_START : ST_DRAIN;
            w_wcnt_nxt  = '0;
          end else if (in_last) begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b1;
            w_wcnt_nxt  = '0;
          end else begin
            w_state_nxt = ST_LOAD;
            w_wcnt_nxt  = r_wcnt + 4'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (w_in_fire && in_last) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
        end
      end
      ST_START: begin
        w_state_nxt = ST_FEED;
        w_fcnt_nxt  = '0;
      end
      ST_FEED: begin
        if (r_fcnt == WCNT_LAST) begin
          w_state_nxt = ST_WAIT;
          w_fcnt_nxt  = '0;
          w_tcnt_nxt  = '0;
        end else begin
          w_fcnt_nxt  = r_fcnt + 4'd1;
        end
      end
      ST_WAIT: begin
        if (sha_eoc) begin
          w_state_nxt = ST_READ;
          w_tcnt_nxt  = '0;
          w_rcnt_nxt  = '0;
        end else if (r_tcnt == TCNT_LAST) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
          w_tcnt_nxt  = '0;
        end else begin
          w_tcnt_nxt  = r_tcnt + 1'b1;
        end
      end
      ST_READ: begin
        if (r_rcnt == RCNT_LAST) begin
          w_state_nxt = ST_DONE;
          w_rcnt_nxt  = '0;
        end else begin
          w_rcnt_nxt  = r_rcnt + 3'd1;
        end
      end
      ST_DONE: begin
        if (dig_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_wcnt        <= '0;
      r_fcnt        <= '0;
      r_rcnt        <= '0;
      r_tcnt        <= '0;
      r_err         <= 1'b0;
      r_busy        <= 1'b0;
      r_sha_soc     <= 1'b0;
      r_sha_data_oe <= 1'b0;
      r_sha_data_o  <= '0;
      r_sha_rd      <= 1'b0;
      r_dig_valid   <= 1'b0;
      r_dig_data    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state       <= w_state_nxt;
      r_wcnt        <= w_wcnt_nxt;
      r_fcnt        <= w_fcnt_nxt;
      r_rcnt        <= w_rcnt_nxt;
      r_tcnt        <= w_tcnt_nxt;
      r_err         <= w_err_nxt;
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_sha_soc     <= (w_state_nxt == ST_START);
      r_sha_data_oe <= (w_state_nxt == ST_FEED);
      r_sha_data_o  <= (w_state_nxt == ST_FEED) ? w_buf_rdata : '0;
      r_sha_rd      <= (w_state_nxt == ST_READ);
      r_dig_valid   <= (w_state_nxt == ST_DONE);
      if (r_state == ST_READ) r_dig_data[w_dig_lsb +: WORD_W] <= sha_data_i;
    end
  end

  assign err         = r_err;
  assign busy        = r_busy;
  assign sha_soc     = r_sha_soc;
  assign sha_data_oe = r_sha_data_oe;
  assign sha_data_o  = r_sha_data_o;
  assign sha_rd      = r_sha_rd;
  assign dig_valid   = r_dig_valid;
  assign dig_data    = r_dig_data;

endmodule
